// File: rtl/gmii_tx_ifg_ctrl_pkg.sv
// Shared constants for the GMII tx inter-frame-gap stage: defaults, FIFO entry layout, FSM states.
package gmii_tx_ifg_ctrl_pkg;
   localparam int IFG_BYTES_DFLT     = 12;
   localparam int MAX_FRM_BYTES_DFLT = 1526;
   localparam int FIFO_AW_DFLT       = 11;

   // FIFO entry = {eof, er, d[7:0]}
   localparam int ENT_W   = 10;
   localparam int ENT_EOF = 9;
   localparam int ENT_ER  = 8;

   typedef enum logic [1:0] {W_IDLE, W_WR, W_DISCARD} wr_state_e;
   typedef enum logic [1:0] {R_IDLE, R_SEND, R_GAP} rd_state_e;
endpackage

// File: rtl/gmii_byte_fifo.sv
// Single-clock FIFO with registered read data and occupancy output; pointers carry one wrap bit.
module gmii_byte_fifo #(
   parameter int AW = 11,
   parameter int DW = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_wr,
   input  logic [DW-1:0] i_wdata,
   input  logic          i_rd,
   output logic [DW-1:0] o_rdata,
   output logic          o_empty,
   output logic          o_full,
   output logic [AW:0]   o_count
);
   logic [DW-1:0] r_mem [2**AW];
   logic [AW:0]   r_wptr, r_rptr;
   logic [DW-1:0] r_rdata;
   logic          w_wr, w_rd;

   assign o_empty = (r_wptr == r_rptr);
   assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign o_count = r_wptr - r_rptr;
   assign o_rdata = r_rdata;
   assign w_wr    = i_wr & ~o_full;
   assign w_rd    = i_rd & ~o_empty;

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_rdata <= '0;
      end else begin
         if (w_wr) r_wptr <= r_wptr + 1'b1;
         if (w_rd) begin
            r_rptr  <= r_rptr + 1'b1;
            r_rdata <= r_mem[r_rptr[AW-1:0]];
         end
      end
   end
endmodule

// File: rtl/gmii_tx_ifg_ctrl.sv
// GMII tx stage: buffers frames cut-through, enforces a minimum IFG and a maximum frame length,
// dropping whole frames that cannot be buffered.
module gmii_tx_ifg_ctrl
   import gmii_tx_ifg_ctrl_pkg::*;
#(
   parameter int IFG_BYTES     = IFG_BYTES_DFLT,
   parameter int MAX_FRM_BYTES = MAX_FRM_BYTES_DFLT,
   parameter int FIFO_AW       = FIFO_AW_DFLT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       gmii_tx_en_i,
   input  logic       gmii_tx_er_i,
   input  logic [7:0] gmii_txd_i,
   output logic       gmii_tx_en,
   output logic       gmii_tx_er,
   output logic [7:0] gmii_txd,
   output logic       frm_drop,
   output logic       frm_trunc
);
   localparam int IW = $clog2(IFG_BYTES + 1);
   localparam int LW = $clog2(MAX_FRM_BYTES + 1);
   // Highest occupancy at SOF that still leaves room for a maximum-length frame
   localparam int ROOM_MAX = 2**FIFO_AW - MAX_FRM_BYTES;

   logic            r_en, r_er;
   logic [7:0]      r_d;
   wr_state_e       r_wr_st, w_wr_nxt;
   rd_state_e       r_rd_st, w_rd_nxt;
   logic [LW-1:0]   r_len, w_len_nxt;
   logic [IW-1:0]   r_ifg, w_ifg_nxt;
   logic            r_tx_en, w_tx_en_nxt;
   logic            r_drop, r_trunc, w_drop, w_trunc;
   logic            w_eof, w_room, w_wr_en, w_rd_en;
   logic [ENT_W-1:0] w_wdata, w_rdata;
   logic            w_empty, w_full;
   logic [FIFO_AW:0] w_count;

   assign w_eof  = r_en & ~gmii_tx_en_i;
   assign w_room = (w_count <= (FIFO_AW+1)'(ROOM_MAX));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_en    <= 1'b0;
         r_er    <= 1'b0;
         r_d     <= '0;
         r_wr_st <= W_IDLE;
         r_rd_st <= R_IDLE;
         r_len   <= '0;
         r_ifg   <= IW'(IFG_BYTES);
         r_tx_en <= 1'b0;
         r_drop  <= 1'b0;
         r_trunc <= 1'b0;
      end else begin
         r_en    <= gmii_tx_en_i;
         r_er    <= gmii_tx_er_i;
         r_d     <= gmii_txd_i;
         r_wr_st <= w_wr_nxt;
         r_rd_st <= w_rd_nxt;
         r_len   <= w_len_nxt;
         r_ifg   <= w_ifg_nxt;
         r_tx_en <= w_tx_en_nxt;
         r_drop  <= w_drop;
         r_trunc <= w_trunc;
      end
   end

   always_comb begin
      w_wr_nxt  = r_wr_st;
      w_len_nxt = r_len;
      w_wr_en   = 1'b0;
      w_drop    = 1'b0;
      w_trunc   = 1'b0;
      w_wdata   = {w_eof, r_er, r_d};
      case (r_wr_st)
         W_IDLE: if (r_en) begin
            if (w_room) begin
               w_wr_en   = 1'b1;
               w_len_nxt = LW'(1);
               if (!w_eof) w_wr_nxt = W_WR;
            end else begin
               w_drop = 1'b1;
               if (!w_eof) w_wr_nxt = W_DISCARD;
            end
         end
         W_WR: begin
            if (r_en) begin
               w_wr_en   = 1'b1;
               w_len_nxt = r_len + 1'b1;
               if (w_eof) begin
                  w_wr_nxt = W_IDLE;
               end else if (r_len == LW'(MAX_FRM_BYTES - 1)) begin
                  // Close the frame on the wire with an error-marked last byte
                  w_wdata[ENT_EOF] = 1'b1;
                  w_wdata[ENT_ER]  = 1'b1;
                  w_trunc  = 1'b1;
                  w_wr_nxt = W_DISCARD;
               end
            end else begin
               w_wr_nxt = W_IDLE;
            end
         end
         W_DISCARD: if (!r_en || w_eof) w_wr_nxt = W_IDLE;
         default: w_wr_nxt = W_IDLE;
      endcase
   end

   always_comb begin
      w_rd_nxt    = r_rd_st;
      w_ifg_nxt   = r_ifg;
      w_rd_en     = 1'b0;
      w_tx_en_nxt = 1'b0;
      case (r_rd_st)
         R_IDLE: if (!w_empty && r_ifg == IW'(IFG_BYTES)) begin
            w_rd_en     = 1'b1;
            w_tx_en_nxt = 1'b1;
            w_rd_nxt    = R_SEND;
         end
         R_SEND: begin
            if (w_rdata[ENT_EOF]) begin
               w_rd_nxt  = R_GAP;
               w_ifg_nxt = '0;
            end else begin
               w_rd_en     = 1'b1;
               w_tx_en_nxt = 1'b1;
            end
         end
         R_GAP: begin
            // The current idle cycle completes the gap, so the next frame may launch now
            if (r_ifg >= IW'(IFG_BYTES - 1)) begin
               w_ifg_nxt = IW'(IFG_BYTES);
               if (!w_empty) begin
                  w_rd_en     = 1'b1;
                  w_tx_en_nxt = 1'b1;
                  w_rd_nxt    = R_SEND;
               end else begin
                  w_rd_nxt = R_IDLE;
               end
            end else begin
               w_ifg_nxt = r_ifg + 1'b1;
            end
         end
         default: w_rd_nxt = R_IDLE;
      endcase
   end

   gmii_byte_fifo #(.AW(FIFO_AW), .DW(ENT_W)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_wr    (w_wr_en),
      .i_wdata (w_wdata),
      .i_rd    (w_rd_en),
      .o_rdata (w_rdata),
      .o_empty (w_empty),
      .o_full  (w_full),
      .o_count (w_count)
   );

   assign gmii_tx_en = r_tx_en;
   assign gmii_tx_er = r_tx_en & w_rdata[ENT_ER];
   assign gmii_txd   = r_tx_en ? w_rdata[7:0] : 8'h00;
   assign frm_drop   = r_drop;
   assign frm_trunc  = r_trunc;

   a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(r_rd_st == R_SEND && w_rd_en && w_empty));
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(w_wr_en && w_full));
endmodule

// File: tb/tb_gmii_tx_ifg_ctrl.sv
// Bench for gmii_tx_ifg_ctrl: queue-based timing model checked every cycle, plus literal frame checks.
module tb_gmii_tx_ifg_ctrl;
   localparam int IFG   = 12;
   localparam int MAXF  = 1526;
   localparam int DEPTH = 2048;
   localparam int NF    = 256;

   logic       clk = 1'b0, rst_n = 1'b0;
   logic       tx_en_i = 1'b0, tx_er_i = 1'b0;
   logic [7:0] txd_i = 8'h00;
   logic       tx_en, tx_er, frm_drop, frm_trunc;
   logic [7:0] txd;
   int total = 0, bad = 0, cyc = 0, g_sof = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   gmii_tx_ifg_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .gmii_tx_en_i(tx_en_i), .gmii_tx_er_i(tx_er_i), .gmii_txd_i(txd_i),
      .gmii_tx_en(tx_en), .gmii_tx_er(tx_er), .gmii_txd(txd),
      .frm_drop(frm_drop), .frm_trunc(frm_trunc)
   );

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Model: a byte registered at cycle c is readable from c+1; a frame leaves the buffer one cycle
   // after its head is readable, but no sooner than IFG idle cycles after the previous eof.
   typedef struct { logic [7:0] d; logic er; logic eof; int vis; } ent_t;
   ent_t q[$];
   logic m_en_h1 = 0, m_en_h2 = 0, m_er_h1 = 0;
   logic [7:0] m_d_h1 = 0;
   bit   m_acc = 0, m_pdrop = 0, m_ptrunc = 0, m_infrm = 0;
   int   m_k = 0, m_last_eof = -100, m_drops = 0;
   logic e_en, e_er, e_drop, e_trunc;
   logic [7:0] e_d;

   always @(negedge clk) begin
      ent_t e;
      e_en = 0; e_er = 0; e_d = 8'h00; e_drop = 0; e_trunc = 0;
      if (!rst_n) begin
         q.delete();
         m_en_h1 = 0; m_en_h2 = 0; m_er_h1 = 0; m_d_h1 = 8'h00;
         m_acc = 0; m_pdrop = 0; m_ptrunc = 0; m_infrm = 0; m_k = 0; m_last_eof = -100;
      end else begin
         e_drop = m_pdrop; e_trunc = m_ptrunc; m_pdrop = 0; m_ptrunc = 0;
         if (m_infrm || (q.size() > 0 && q[0].vis <= cyc - 1 && cyc - m_last_eof > IFG)) begin
            if (q.size() == 0) begin
               bad++;
               $display("FAIL model_underflow at cycle %0d: got empty buffer expected data", cyc);
               m_infrm = 0;
            end else begin
               e = q.pop_front();
               e_en = 1; e_er = e.er; e_d = e.d;
               m_infrm = !e.eof;
               if (e.eof) m_last_eof = cyc;
            end
         end
         if (m_en_h1) begin
            if (!m_en_h2) begin
               m_acc = (q.size() <= DEPTH - MAXF);
               m_k = 0;
               if (!m_acc) begin m_pdrop = 1; m_drops++; end
            end
            if (m_acc && m_k < MAXF) begin
               e.d = m_d_h1; e.er = m_er_h1; e.eof = !tx_en_i; e.vis = cyc + 1;
               if (m_k == MAXF - 1 && tx_en_i) begin e.eof = 1; e.er = 1; m_ptrunc = 1; end
               q.push_back(e);
               m_k++;
            end
         end
         m_en_h2 = m_en_h1; m_en_h1 = tx_en_i; m_er_h1 = tx_er_i; m_d_h1 = txd_i;
      end
      total++;
      if ({tx_en, tx_er, txd, frm_drop, frm_trunc} !== {e_en, e_er, e_d, e_drop, e_trunc}) begin
         bad++;
         $display("FAIL cycle %0d en/er/d/drop/trunc got %b/%b/%h/%b/%b expected %b/%b/%h/%b/%b",
                  cyc, tx_en, tx_er, txd, frm_drop, frm_trunc, e_en, e_er, e_d, e_drop, e_trunc);
      end
   end

   // Output frame monitor (observed values only)
   int n_frm = 0, dut_drops = 0, dut_truncs = 0;
   int f_start[NF], f_end[NF], f_len[NF];
   logic f_ler[NF];
   logic [7:0] f_first[NF];
   logic mon_prev = 1'b0;
   always @(negedge clk) begin
      if (tx_en && !mon_prev && n_frm < NF) begin
         f_start[n_frm] = cyc; f_len[n_frm] = 0; f_first[n_frm] = txd; n_frm++;
      end
      if (tx_en && n_frm > 0) begin
         f_len[n_frm-1]++; f_end[n_frm-1] = cyc; f_ler[n_frm-1] = tx_er;
      end
      mon_prev = tx_en;
      dut_drops += int'(frm_drop);
      dut_truncs += int'(frm_trunc);
   end

   task automatic drive(input logic en, input logic er, input logic [7:0] d);
      @(posedge clk); #1;
      tx_en_i = en; tx_er_i = er; txd_i = d;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b0, 8'h00);
   endtask

   task automatic send_frame(input int len, input logic [7:0] id, input int er_at);
      for (int i = 0; i < len; i++) begin
         drive(1'b1, (i == er_at), 8'(id + i));
         if (i == 0) g_sof = cyc;
      end
      drive(1'b0, 1'b0, 8'h00);
   endtask

   initial begin
      int nf0, sof, d0, t0, m0, sent, badgap;
      repeat (3) @(posedge clk);
      #1;
      check("rst_tx_en", tx_en, 0);
      check("rst_txd", txd, 0);
      check("rst_drop_trunc", {frm_drop, frm_trunc}, 0);
      rst_n = 1'b1;
      idle(5);

      // 1: single frame on an idle line
      nf0 = n_frm;
      send_frame(64, 8'h10, -1);
      sof = g_sof;
      idle(30);
      check("t1_frames", n_frm - nf0, 1);
      check("t1_latency", f_start[nf0] - sof, 3);
      check("t1_len", f_len[nf0], 64);
      check("t1_first", f_first[nf0], 8'h10);
      check("t1_drop_trunc", dut_drops + dut_truncs, 0);

      // 2: short input gap is stretched to exactly IFG
      nf0 = n_frm;
      send_frame(64, 8'h20, -1);
      idle(3);
      send_frame(64, 8'h40, 10);
      idle(100);
      check("t2_frames", n_frm - nf0, 2);
      check("t2_gap", f_start[nf0+1] - f_end[nf0] - 1, 12);
      check("t2_len2", f_len[nf0+1], 64);
      check("t2_first2", f_first[nf0+1], 8'h40);

      // 3: 20 frames with 1-cycle input gaps
      nf0 = n_frm; d0 = dut_drops;
      for (int i = 0; i < 20; i++) send_frame(64, 8'(i * 8), -1);
      idle(600);
      badgap = 0;
      for (int i = nf0 + 1; i < nf0 + 20; i++)
         if (f_start[i] - f_end[i-1] - 1 != 12) badgap++;
      check("t3_frames", n_frm - nf0, 20);
      check("t3_bad_gaps", badgap, 0);
      check("t3_drops", dut_drops - d0, 0);

      // 4: oversize frame is truncated, next frame is normal
      nf0 = n_frm; t0 = dut_truncs;
      send_frame(1600, 8'h55, -1);
      send_frame(64, 8'h66, -1);
      idle(200);
      check("t4_frames", n_frm - nf0, 2);
      check("t4_len", f_len[nf0], 1526);
      check("t4_last_er", f_ler[nf0], 1);
      check("t4_truncs", dut_truncs - t0, 1);
      check("t4_next_len", f_len[nf0+1], 64);
      check("t4_next_first", f_first[nf0+1], 8'h66);

      // 5: build backlog until a SOF finds too little room, then drain and send again
      nf0 = n_frm; d0 = dut_drops; m0 = m_drops; sent = 0;
      while (m_drops == m0 && sent < 90) begin
         send_frame(64, 8'(sent), -1);
         sent++;
      end
      idle(1200);
      send_frame(64, 8'hA5, -1);
      idle(200);
      check("t5_drops", dut_drops - d0, 1);
      check("t5_frames", n_frm - nf0, sent);
      check("t5_after_first", f_first[n_frm-1], 8'hA5);
      check("t5_after_len", f_len[n_frm-1], 64);

      // 6: reset mid-frame cuts output at once; a later frame is clean
      for (int i = 0; i < 30; i++) drive(1'b1, 1'b0, 8'(8'hC0 + i));
      @(posedge clk); #1;
      check("t6_pre_en", tx_en, 1);
      rst_n = 1'b0; tx_en_i = 1'b0; txd_i = 8'h00;
      #1;
      check("t6_cut", tx_en, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      idle(5);
      nf0 = n_frm;
      send_frame(64, 8'h77, -1);
      sof = g_sof;
      idle(100);
      check("t6_frames", n_frm - nf0, 1);
      check("t6_latency", f_start[nf0] - sof, 3);
      check("t6_len", f_len[nf0], 64);
      check("t6_first", f_first[nf0], 8'h77);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
